// File: rtl/rv_pkg.sv
// Shared types and constants for the rv core front end.
// Fetch buffer entries pair an instruction word with the PC it was fetched from.
package rv_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_REQ
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & INSTR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous instruction buffer holding fetch entries in arrival order.
// Head is read from the storage array; a pushed entry is visible the cycle after.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push && !flush && !srst) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // flush outranks push: an entry arriving in the flush cycle is dropped
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch unit: PC, request FSM on a req/gnt/rvalid port, response
// buffering and redirect flush. Feeds rv_decoder through a valid/ready handshake.
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state_reg;
  logic          stale_reg;
  logic [31:0]   pc_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   resp_pc_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] discard_reg;

  logic [31:0]   pc_next;
  logic [31:0]   resp_pc_next;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] discard_next;

  logic          credit_ok;
  logic          can_issue;
  logic          gnt_fire;
  logic          stale_fire;
  logic          rvalid_eff;
  logic          discard_dec;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata;
  fetch_entry_t  fifo_rdata;

  // Outstanding requests plus buffered entries never exceed the buffer size,
  // so every response always has a slot waiting for it.
  assign credit_ok = ({1'b0, outstanding_reg} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign can_issue = (state_reg == FETCH_IDLE) && credit_ok && !redirect_i;

  assign instr_req_o  = !rst_i && ((state_reg == FETCH_REQ) || can_issue);
  assign instr_addr_o = (state_reg == FETCH_REQ) ? addr_reg : pc_reg;

  assign gnt_fire    = instr_req_o && instr_gnt_i;
  assign stale_fire  = gnt_fire && stale_reg;
  assign rvalid_eff  = instr_rvalid_i && (outstanding_reg != '0);
  assign discard_dec = rvalid_eff && (discard_reg != '0);

  assign fifo_push  = rvalid_eff && !discard_dec && !redirect_i;
  assign fifo_pop   = instr_valid_o && instr_ready_i;
  assign fifo_wdata = '{pc: resp_pc_reg, instr: instr_rdata_i};

  assign outstanding_next = outstanding_reg + CW'(gnt_fire) - CW'(rvalid_eff);

  // A redirect drops everything already granted; a stale request still
  // waiting for its grant joins the discard count once it is accepted.
  assign discard_next = redirect_i ? outstanding_next
                                   : discard_reg - CW'(discard_dec) + CW'(stale_fire);

  assign pc_next = redirect_i             ? align_pc(redirect_pc_i) :
                   (gnt_fire && !stale_reg) ? pc_reg + 32'd4        :
                                              pc_reg;

  // Surviving responses are sequential from the last redirect target.
  assign resp_pc_next = redirect_i ? align_pc(redirect_pc_i) :
                        fifo_push  ? resp_pc_reg + 32'd4     :
                                     resp_pc_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= FETCH_IDLE;
      stale_reg       <= 1'b0;
      pc_reg          <= BOOT_ADDR;
      addr_reg        <= BOOT_ADDR;
      resp_pc_reg     <= BOOT_ADDR;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      if (gnt_fire) begin
        state_reg <= FETCH_IDLE;
        stale_reg <= 1'b0;
      end else if (instr_req_o) begin
        state_reg <= FETCH_REQ;
        addr_reg  <= instr_addr_o;
        if (redirect_i) begin
          stale_reg <= 1'b1;
        end
      end
    end
  end

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk_i),
    .srst  (rst_i),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .flush (redirect_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? 32'h0 : fifo_rdata.instr;
  assign instr_pc_o    = fifo_empty ? 32'h0 : fifo_rdata.pc;

  assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_push && fifo_full));

endmodule

// File: doc/rv_fetch.md
Name: rv_fetch

Overview:
Instruction fetch unit; it produces the 32-bit instruction word consumed by rv_decoder.
- Maintains the PC and issues word requests on a req/gnt/rvalid instruction-memory port.
- Buffers responses with their PCs in a small FIFO and presents them downstream with a valid/ready handshake.
- Supports a PC redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- BOOT_ADDR, 32'h0000_0000, first PC fetched after reset (bits[1:0] must be 0).
- FIFO_DEPTH, 4, instruction buffer entries; also the cap on (outstanding requests + buffered entries); legal range 2..8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  word-aligned fetch address
- instr_gnt_i  in  1  request accepted this cycle
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- redirect_i  in  1  load new PC, flush
- redirect_pc_i  in  32  new PC; bits[1:0] ignored and forced 0
- instr_valid_o  out  1  instruction available to decode
- instr_ready_i  in  1  decode accepts instruction
- instr_o  out  32  instruction word, drives rv_decoder instr_i
- instr_pc_o  out  32  PC of instr_o

Behaviour:
- Reset (rst_i high at a clock edge): PC=BOOT_ADDR, FIFO empty, outstanding=0, discard=0, stale=0. Outputs: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=0, instr_pc_o=0. Reset mid-transaction abandons all in-flight responses; the memory is reset with the core.
- Memory protocol: once instr_req_o is raised, it and instr_addr_o hold until the cycle instr_gnt_i=1. Responses return in order, at least 1 cycle after their grant. instr_rvalid_i is ignored when outstanding=0.
- Issue rule: assert instr_req_o when no request is pending, (outstanding + fifo_count) < FIFO_DEPTH, and redirect_i=0. The first request is asserted in the first cycle after reset deasserts.
- On grant: PC += 4 (32-bit wrap, FFFF_FFFC -> 0000_0000), outstanding += 1. Back-to-back issue is allowed: a new request may start the cycle after a grant.
- On rvalid:
  - outstanding -= 1.
  - If discard>0, discard -= 1 and the data is dropped.
  - Otherwise push {pc, rdata} into the FIFO. The pushed PC is the address of that request, taken from a PC-per-outstanding queue or derived as head PC plus offset.
  - Simultaneous grant and rvalid: outstanding is unchanged.
- Output: instr_valid_o = FIFO non-empty; instr_o/instr_pc_o = FIFO head. Pop when valid && ready. Push-to-visible latency is 1 cycle (registered FIFO, no bypass). Simultaneous push and pop on a non-empty FIFO keeps the count. Push when full cannot occur because the credit rule prevents it; assert this.
- Redirect (redirect_i=1, highest priority):
  - Next cycle: PC=redirect_pc_i&~3, FIFO empty, instr_valid_o=0.
  - discard = outstanding after this cycle's grant/rvalid updates, i.e. every granted-but-unreturned response is dropped. An rvalid in the redirect cycle itself is dropped.
  - If a request is pending ungranted, it stays asserted with its old address. When granted it adds 1 to discard (stale flag), and the PC is not incremented for it.
  - New-PC request is raised the cycle after the redirect, or after the stale grant.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Latency: with a zero-wait memory (gnt same cycle, rvalid next cycle), instr_valid_o is asserted 2 cycles after instr_req_o. Throughput is 1 instruction/cycle with FIFO_DEPTH≥3 and ready held high.

Decomposition:
- rv_pkg additions: fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}; constant INSTR_ALIGN_MASK = 32'hFFFF_FFFC.
- Sub-module rv_fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, ports push/pop/flush/full/empty/count. flush has priority over push.
- rv_fetch contains the PC, request FSM (IDLE, REQ, with stale flag), and the outstanding/discard counters.

Test Plan:
- Reset, zero-wait memory returning addr^32'h13, ready=1 -> instr_req_o in cycle 1; fetch addresses 0,4,8,...; instr_valid_o in cycle 3 with instr_o=32'h13, instr_pc_o=0; then 1 instr/cycle.
- ready=0 held, memory zero-wait -> exactly FIFO_DEPTH (4) grants, then instr_req_o=0; raise ready -> entries PC 0,4,8,C in order, none lost.
- Grant delayed 3 cycles -> instr_req_o and instr_addr_o stable all 3 cycles; PC advances only on the grant cycle.
- 2 requests in flight, redirect_i with redirect_pc_i=32'h0000_1003 -> both responses dropped, FIFO empties next cycle, next fetch address 32'h0000_1000, first output pc 1000.
- Redirect while a request is pending ungranted (addr 8) -> address 8 held until gnt, its response discarded, then fetch 32'h0000_1000.
- Redirect to 32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000; rst_i mid-flight -> all outputs at reset values next cycle, restart at BOOT_ADDR.
